// File: rtl/dpram_acc.sv
// dpram_acc: dual-port buffer for signed fixed-point words.
// Port A does read / write / saturating accumulate through a one-entry commit
// register (S2) with forwarding; port B is a plain read-first read/write port.
module dpram_acc #(
    parameter int unsigned AWIDTH    = 10,
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned NUM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] address_a,
    input  logic              wren_a,
    input  logic              acc_a,
    input  logic [DWIDTH-1:0] data_a,
    output logic [DWIDTH-1:0] out_a,
    output logic              sat_a,
    input  logic [AWIDTH-1:0] address_b,
    input  logic              wren_b,
    input  logic [DWIDTH-1:0] data_b,
    output logic [DWIDTH-1:0] out_b,
    output logic              collision
);

    localparam int unsigned IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [AWIDTH:0]   DEPTH = (AWIDTH+1)'(NUM_WORDS);
    localparam logic [DWIDTH-1:0] SMAX  = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] SMIN  = {1'b1, {(DWIDTH-1){1'b0}}};

    logic [DWIDTH-1:0] mem [NUM_WORDS];

    logic              s2_valid_q, s2_valid_d;
    logic [AWIDTH-1:0] s2_addr_q,  s2_addr_d;
    logic [DWIDTH-1:0] s2_value_q, s2_value_d;
    logic [DWIDTH-1:0] out_a_q,    out_a_d;
    logic [DWIDTH-1:0] out_b_q,    out_b_d;
    logic              sat_a_q,    sat_a_d;
    logic              coll_q,     coll_d;

    logic              a_in_range, b_in_range;
    logic [DWIDTH-1:0] mem_a_rd, old_a, acc_val;
    logic [DWIDTH:0]   sum;
    logic              ovf, b_block, b_we;

    // Next-state: forwarding, saturating add, S2 load and port B arbitration
    always_comb begin
        a_in_range = ({1'b0, address_a} < DEPTH);
        b_in_range = ({1'b0, address_b} < DEPTH);
        mem_a_rd   = a_in_range ? mem[address_a[IW-1:0]] : '0;
        old_a      = (s2_valid_q && (s2_addr_q == address_a)) ? s2_value_q : mem_a_rd;

        sum     = {old_a[DWIDTH-1], old_a} + {data_a[DWIDTH-1], data_a};
        ovf     = sum[DWIDTH] ^ sum[DWIDTH-1];
        acc_val = ovf ? (sum[DWIDTH] ? SMIN : SMAX) : sum[DWIDTH-1:0];

        // Out-of-range writes never enter S2, so they can neither commit nor forward
        s2_valid_d = wren_a && a_in_range;
        s2_addr_d  = address_a;
        s2_value_d = acc_a ? acc_val : data_a;
        out_a_d    = old_a;
        sat_a_d    = wren_a && acc_a && ovf;

        out_b_d = b_in_range ? mem[address_b[IW-1:0]] : '0;
        b_block = s2_valid_q && (s2_addr_q == address_b);
        b_we    = wren_b && b_in_range && !b_block;
        coll_d  = wren_b && b_block;
    end

    // Pipeline and output registers; reset discards any pending commit
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_value_q <= '0;
            out_a_q    <= '0;
            out_b_q    <= '0;
            sat_a_q    <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_addr_q  <= s2_addr_d;
            s2_value_q <= s2_value_d;
            out_a_q    <= out_a_d;
            out_b_q    <= out_b_d;
            sat_a_q    <= sat_a_d;
            coll_q     <= coll_d;
        end
    end

    // Storage: S2 commit and port B write; contents survive reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (s2_valid_q) mem[s2_addr_q[IW-1:0]] <= s2_value_q;
            if (b_we)       mem[address_b[IW-1:0]] <= data_b;
        end
    end

    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign sat_a     = sat_a_q;
    assign collision = coll_q;

endmodule

// File: tb/tb_dpram_acc.sv
// Directed testbench for dpram_acc (8-bit words, 1000-word depth).
module tb_dpram_acc;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] address_a, address_b;
    logic       wren_a, acc_a, wren_b;
    logic [7:0] data_a, data_b;
    logic [7:0] out_a, out_b;
    logic       sat_a, collision;

    int total = 0;
    int bad   = 0;

    dpram_acc #(.AWIDTH(10), .DWIDTH(8), .NUM_WORDS(1000)) dut (
        .clk(clk), .reset(reset),
        .address_a(address_a), .wren_a(wren_a), .acc_a(acc_a), .data_a(data_a),
        .out_a(out_a), .sat_a(sat_a),
        .address_b(address_b), .wren_b(wren_b), .data_b(data_b),
        .out_b(out_b), .collision(collision)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic [9:0] a, input logic wr, input logic ac, input logic [7:0] d);
        address_a = a; wren_a = wr; acc_a = ac; data_a = d;
    endtask

    task automatic drv_b(input logic [9:0] a, input logic wr, input logic [7:0] d);
        address_b = a; wren_b = wr; data_b = d;
    endtask

    task automatic idle();
        drv_a(10'h3FF, 1'b0, 1'b0, 8'h00);
        drv_b(10'h3FF, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick(); tick();
        total++;
        if ({out_a, out_b, sat_a, collision} !== 18'h0) begin
            bad++;
            $display("FAIL reset_outputs: got out_a=%h out_b=%h sat=%b coll=%b, want all 0",
                     out_a, out_b, sat_a, collision);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        drv_a(10'h005, 1'b1, 1'b0, 8'h14); tick();
        drv_a(10'h005, 1'b0, 1'b0, 8'h00); tick();
        total++;
        if (out_a !== 8'h14) begin bad++; $display("FAIL fwd_read: out_a=%h want 14", out_a); end
        idle(); tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_out [3];
        exp_out[0] = 8'h08; exp_out[1] = 8'h14; exp_out[2] = 8'h18;
        drv_a(10'h010, 1'b1, 1'b0, 8'h08); tick();
        drv_a(10'h010, 1'b1, 1'b1, 8'h0C); tick();
        total++;
        if (out_a !== exp_out[0] || sat_a !== 1'b0) begin
            bad++; $display("FAIL b2b_e1: out_a=%h sat=%b want %h 0", out_a, sat_a, exp_out[0]);
        end
        drv_a(10'h010, 1'b1, 1'b1, 8'h04); tick();
        total++;
        if (out_a !== exp_out[1] || sat_a !== 1'b0) begin
            bad++; $display("FAIL b2b_e2: out_a=%h sat=%b want %h 0", out_a, sat_a, exp_out[1]);
        end
        drv_a(10'h010, 1'b0, 1'b0, 8'h00); tick();
        total++;
        if (out_a !== exp_out[2] || sat_a !== 1'b0) begin
            bad++; $display("FAIL b2b_e3: out_a=%h sat=%b want %h 0", out_a, sat_a, exp_out[2]);
        end
        idle(); tick();
    endtask

    task automatic test_saturation();
        logic [9:0] addr [3];
        logic [7:0] init [3];
        logic [7:0] add  [3];
        logic [7:0] res  [3];
        logic       pls  [3];
        addr[0] = 10'h020; init[0] = 8'h78; add[0] = 8'h10; res[0] = 8'h7F; pls[0] = 1'b1;
        addr[1] = 10'h021; init[1] = 8'h88; add[1] = 8'hF0; res[1] = 8'h80; pls[1] = 1'b1;
        addr[2] = 10'h022; init[2] = 8'h08; add[2] = 8'hF8; res[2] = 8'h00; pls[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv_a(addr[i], 1'b1, 1'b0, init[i]); tick();
            drv_a(addr[i], 1'b1, 1'b1, add[i]);  tick();
            total++;
            if (sat_a !== pls[i] || out_a !== init[i]) begin
                bad++; $display("FAIL sat_pulse[%0d]: sat=%b out_a=%h want %b %h", i, sat_a, out_a, pls[i], init[i]);
            end
            drv_a(addr[i], 1'b0, 1'b0, 8'h00); tick();
            total++;
            if (sat_a !== 1'b0 || out_a !== res[i]) begin
                bad++; $display("FAIL sat_result[%0d]: sat=%b out_a=%h want 0 %h", i, sat_a, out_a, res[i]);
            end
            idle(); tick();
            drv_b(addr[i], 1'b0, 8'h00); tick();
            total++;
            if (out_b !== res[i]) begin
                bad++; $display("FAIL sat_mem[%0d]: out_b=%h want %h", i, out_b, res[i]);
            end
            idle();
        end
        tick();
    endtask

    task automatic test_collision();
        drv_a(10'h030, 1'b1, 1'b0, 8'h20); tick();
        idle(); drv_b(10'h030, 1'b1, 8'h28); tick();
        total++;
        if (collision !== 1'b1) begin bad++; $display("FAIL coll_pulse: collision=%b want 1", collision); end
        idle(); tick();
        total++;
        if (collision !== 1'b0) begin bad++; $display("FAIL coll_clear: collision=%b want 0", collision); end
        drv_b(10'h030, 1'b0, 8'h00); tick();
        total++;
        if (out_b !== 8'h20) begin bad++; $display("FAIL coll_mem: out_b=%h want 20", out_b); end

        drv_a(10'h030, 1'b1, 1'b0, 8'h21); drv_b(10'h3FF, 1'b0, 8'h00); tick();
        idle(); drv_b(10'h031, 1'b1, 8'h28); tick();
        total++;
        if (collision !== 1'b0) begin bad++; $display("FAIL nocoll_pulse: collision=%b want 0", collision); end
        drv_a(10'h030, 1'b0, 1'b0, 8'h00); drv_b(10'h031, 1'b0, 8'h00); tick();
        total++;
        if (out_a !== 8'h21 || out_b !== 8'h28) begin
            bad++; $display("FAIL nocoll_mem: out_a=%h out_b=%h want 21 28", out_a, out_b);
        end
        idle(); tick();
    endtask

    task automatic test_port_b();
        drv_b(10'h00A, 1'b1, 8'hFC); tick();
        drv_b(10'h00A, 1'b0, 8'h00); tick();
        total++;
        if (out_b !== 8'hFC) begin bad++; $display("FAIL b_rw: out_b=%h want FC", out_b); end
        idle();
        drv_a(10'h005, 1'b1, 1'b0, 8'h33); tick();
        idle(); drv_b(10'h005, 1'b0, 8'h00); tick();
        total++;
        if (out_b !== 8'h14) begin bad++; $display("FAIL b_read_first: out_b=%h want 14", out_b); end
        tick();
        total++;
        if (out_b !== 8'h33) begin bad++; $display("FAIL b_after_commit: out_b=%h want 33", out_b); end
        idle(); tick();
    endtask

    task automatic test_reset_mid_op();
        drv_a(10'h040, 1'b1, 1'b0, 8'h08); tick();
        idle(); tick();
        drv_a(10'h040, 1'b1, 1'b1, 8'h08); tick();
        total++;
        if (out_a !== 8'h08) begin bad++; $display("FAIL mid_acc_old: out_a=%h want 08", out_a); end
        idle(); reset = 1'b1; tick();
        total++;
        if ({out_a, out_b, sat_a, collision} !== 18'h0) begin
            bad++; $display("FAIL mid_reset_outputs: out_a=%h out_b=%h sat=%b coll=%b want all 0",
                            out_a, out_b, sat_a, collision);
        end
        reset = 1'b0;
        drv_a(10'h040, 1'b0, 1'b0, 8'h00); tick();
        total++;
        if (out_a !== 8'h08) begin bad++; $display("FAIL mid_discard_a: out_a=%h want 08", out_a); end
        idle(); drv_b(10'h040, 1'b0, 8'h00); tick(); tick();
        total++;
        if (out_b !== 8'h08) begin bad++; $display("FAIL mid_discard_b: out_b=%h want 08", out_b); end
        idle(); tick();
    endtask

    task automatic test_out_of_range();
        drv_a(10'h3F0, 1'b1, 1'b0, 8'h55); drv_b(10'h3F1, 1'b1, 8'h66); tick();
        drv_a(10'h3F0, 1'b0, 1'b0, 8'h00); drv_b(10'h3F1, 1'b0, 8'h00); tick();
        total++;
        if (out_a !== 8'h00 || out_b !== 8'h00) begin
            bad++; $display("FAIL oor_read: out_a=%h out_b=%h want 00 00", out_a, out_b);
        end
        drv_a(10'h3E7, 1'b1, 1'b0, 8'h5A); drv_b(10'h3FF, 1'b0, 8'h00); tick();
        idle(); tick();
        drv_b(10'h3E7, 1'b0, 8'h00); tick();
        total++;
        if (out_b !== 8'h5A) begin bad++; $display("FAIL last_word: out_b=%h want 5A", out_b); end
        idle(); tick();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_saturation();
        test_collision();
        test_port_b();
        test_reset_mid_op();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
